// File: rtl/trig_delayed_pulse_gen.sv
// Trigger regeneration: adds a fixed transport delay to received WR timestamps,
// queues the deadlines and emits a fixed-width pulse when local WR time reaches each one.
module trig_delayed_pulse_gen #(
    parameter int g_fifo_depth     = 4,
    parameter int g_delay_cycles   = 2500,
    parameter int g_pulse_width    = 125,
    parameter int g_cycles_per_sec = 125000000
) (
    input  logic        clk_ref_i,
    input  logic        rst_n_i,
    input  logic        tm_time_valid_i,
    input  logic [39:0] tm_tai_i,
    input  logic [27:0] tm_cycles_i,
    input  logic        ts_valid_i,
    input  logic [39:0] ts_tai_i,
    input  logic [27:0] ts_cycles_i,
    output logic        pulse_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        missed_o
);

    localparam int AW = $clog2(g_fifo_depth);
    localparam int WW = (g_pulse_width > 1) ? $clog2(g_pulse_width) : 1;
    localparam logic [28:0]   c_delay      = 29'(g_delay_cycles);
    localparam logic [28:0]   c_cps        = 29'(g_cycles_per_sec);
    localparam logic [WW-1:0] c_width_load = WW'(g_pulse_width - 1);
    localparam logic [AW:0]   c_depth      = (AW + 1)'(g_fifo_depth);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE} state_t;

    logic          r_add_valid;
    logic [39:0]   r_add_tai;
    logic [27:0]   r_add_cycles;
    logic [39:0]   r_mem_tai [g_fifo_depth];
    logic [27:0]   r_mem_cyc [g_fifo_depth];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [WW-1:0] r_width;
    logic          r_pulse, r_busy, r_overflow, r_missed;

    logic [28:0]   w_sum;
    logic [AW:0]   w_count_nxt;
    logic [39:0]   w_head_tai;
    logic [27:0]   w_head_cyc;
    logic          w_full, w_empty, w_push, w_pop;
    logic          w_tai_eq, w_at, w_past, w_check, w_pulse_nxt;

    assign w_sum = {1'b0, ts_cycles_i} + c_delay;

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk_ref_i) begin
        if (!rst_n_i) begin
            r_add_valid  <= 1'b0;
            r_add_tai    <= '0;
            r_add_cycles <= '0;
        end else begin
            r_add_valid <= ts_valid_i;
            if (w_sum >= c_cps) begin
                r_add_tai    <= ts_tai_i + 40'd1;
                r_add_cycles <= 28'(w_sum - c_cps);
            end else begin
                r_add_tai    <= ts_tai_i;
                r_add_cycles <= w_sum[27:0];
            end
        end
    end

    // Fullness is taken before any same-cycle pop, so a write into a full queue is dropped.
    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_push      = r_add_valid && !w_full;
    assign w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    assign w_head_tai  = r_mem_tai[r_rd_ptr];
    assign w_head_cyc  = r_mem_cyc[r_rd_ptr];

    // NOTE: the deadline storage is not reset; the count and pointers alone
    // decide which entries are meaningful.
    always_ff @(posedge clk_ref_i) begin
        if (w_push) begin
            r_mem_tai[r_wr_ptr] <= r_add_tai;
            r_mem_cyc[r_wr_ptr] <= r_add_cycles;
        end
    end

    always_ff @(posedge clk_ref_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_overflow <= r_add_valid && w_full;
            r_busy     <= (w_count_nxt != '0) || w_pulse_nxt;
        end
    end

    assign w_tai_eq    = (tm_tai_i == w_head_tai);
    assign w_at        = w_tai_eq && (tm_cycles_i == w_head_cyc);
    assign w_past      = (tm_tai_i > w_head_tai) || (w_tai_eq && (tm_cycles_i > w_head_cyc));
    assign w_check     = (r_state == S_WAIT) && tm_time_valid_i && !w_empty;
    assign w_pop       = w_check && (w_at || w_past);
    assign w_pulse_nxt = (w_check && w_at) || ((r_state == S_PULSE) && (r_width != '0));

    always_ff @(posedge clk_ref_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_pulse  <= 1'b0;
            r_missed <= 1'b0;
            r_width  <= '0;
        end else begin
            r_missed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_push) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_check && w_at) begin
                        r_state <= S_PULSE;
                        r_pulse <= 1'b1;
                        r_width <= c_width_load;
                    end else if (w_check && w_past) begin
                        r_missed <= 1'b1;
                        if (w_count_nxt == '0) r_state <= S_IDLE;
                    end
                end
                S_PULSE: begin
                    if (r_width == '0) begin
                        r_pulse <= 1'b0;
                        r_state <= (w_count_nxt != '0) ? S_WAIT : S_IDLE;
                    end else begin
                        r_width <= r_width - WW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pulse_o    = r_pulse;
    assign busy_o     = r_busy;
    assign overflow_o = r_overflow;
    assign missed_o   = r_missed;

endmodule

// File: tb/tb_trig_delayed_pulse_gen.sv
// Scoreboard bench for trig_delayed_pulse_gen: expected deadlines are queued as
// timestamps are sent and matched against the local time sampled when pulse_o rises.
module tb_trig_delayed_pulse_gen;

    localparam int CPS   = 125000000;
    localparam int DELAY = 2500;
    localparam int PW    = 125;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [39:0] tai;
        logic [27:0] cyc;
    } dl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tm_valid;
    logic [39:0] tm_tai;
    logic [27:0] tm_cyc;
    logic        ts_valid;
    logic [39:0] ts_tai;
    logic [27:0] ts_cyc;
    logic        pulse_o, busy_o, overflow_o, missed_o;

    always #4 clk = ~clk;

    trig_delayed_pulse_gen #(
        .g_fifo_depth    (DEPTH),
        .g_delay_cycles  (DELAY),
        .g_pulse_width   (PW),
        .g_cycles_per_sec(CPS)
    ) dut (
        .clk_ref_i      (clk),
        .rst_n_i        (rst_n),
        .tm_time_valid_i(tm_valid),
        .tm_tai_i       (tm_tai),
        .tm_cycles_i    (tm_cyc),
        .ts_valid_i     (ts_valid),
        .ts_tai_i       (ts_tai),
        .ts_cycles_i    (ts_cyc),
        .pulse_o        (pulse_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .missed_o       (missed_o)
    );

    int          total = 0;
    int          bad   = 0;
    dl_t         pq[$];
    dl_t         mq[$];
    int          exp_ovf   = 0;
    int          pulse_cnt = 0;
    int          miss_cnt  = 0;
    int          ovf_cnt   = 0;
    int          width     = 0;
    logic        prev_pulse = 1'b0, prev_missed = 1'b0, prev_ovf = 1'b0;
    logic [39:0] smp_tai;
    logic [27:0] smp_cyc;
    logic        smp_rst;
    bit          tm_run = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic dl_t deadline(input logic [39:0] t, input logic [27:0] c);
        dl_t         d;
        logic [28:0] s;
        s = {1'b0, c} + 29'(DELAY);
        if (s >= 29'(CPS)) begin
            d.tai = t + 40'd1;
            d.cyc = 28'(s - 29'(CPS));
        end else begin
            d.tai = t;
            d.cyc = s[27:0];
        end
        return d;
    endfunction

    task automatic monitor();
        if (pulse_o && !prev_pulse) begin
            pulse_cnt++;
            width = 1;
            check("pulse_expected", 64'(pq.size() != 0), 1);
            if (pq.size() != 0) begin
                dl_t d;
                d = pq.pop_front();
                check("pulse_tai", 64'(smp_tai), 64'(d.tai));
                check("pulse_cyc", 64'(smp_cyc), 64'(d.cyc));
            end
        end else if (pulse_o) begin
            width++;
        end else if (prev_pulse && smp_rst) begin
            check("pulse_width", 64'(width), 64'(PW));
        end
        if (missed_o) begin
            miss_cnt++;
            check("missed_strobe", 64'(prev_missed), 0);
            check("missed_expected", 64'(mq.size() != 0), 1);
            if (mq.size() != 0) void'(mq.pop_front());
        end
        if (overflow_o) begin
            ovf_cnt++;
            check("ovf_strobe", 64'(prev_ovf), 0);
            check("ovf_expected", 64'(exp_ovf > 0), 1);
            if (exp_ovf > 0) exp_ovf--;
        end
        prev_pulse  = pulse_o;
        prev_missed = missed_o;
        prev_ovf    = overflow_o;
    endtask

    // One clock: capture what the DUT samples, check outputs 1 ns later, drive on the falling edge.
    task automatic tick();
        @(posedge clk);
        smp_tai = tm_tai;
        smp_cyc = tm_cyc;
        smp_rst = rst_n;
        #1;
        monitor();
        @(negedge clk);
        ts_valid = 1'b0;
        if (tm_run) begin
            if (tm_cyc == 28'(CPS - 1)) begin
                tm_cyc = '0;
                tm_tai = tm_tai + 40'd1;
            end else begin
                tm_cyc = tm_cyc + 28'd1;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [39:0] t, input logic [27:0] c);
        ts_valid = 1'b1;
        ts_tai   = t;
        ts_cyc   = c;
        tick();
    endtask

    task automatic set_time(input logic [39:0] t, input logic [27:0] c, input bit running);
        tm_tai = t;
        tm_cyc = c;
        tm_run = running;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        run(3);
        while (busy_o && n < limit) begin
            tick();
            n++;
        end
        check({"idle_", tag}, 64'(busy_o), 0);
    endtask

    initial begin
        int p0, m0, o0;
        rst_n    = 1'b0;
        tm_valid = 1'b0;
        tm_tai   = '0;
        tm_cyc   = '0;
        ts_valid = 1'b0;
        ts_tai   = '0;
        ts_cyc   = '0;
        run(3);
        check("rst_pulse", 64'(pulse_o), 0);
        check("rst_busy", 64'(busy_o), 0);
        check("rst_ovf", 64'(overflow_o), 0);
        check("rst_missed", 64'(missed_o), 0);
        rst_n = 1'b1;
        run(2);

        // Basic: (10,1000) -> deadline (10,3500)
        set_time(40'd10, 28'd0, 1'b1);
        tm_valid = 1'b1;
        p0 = pulse_cnt; m0 = miss_cnt; o0 = ovf_cnt;
        pq.push_back(deadline(40'd10, 28'd1000));
        send(40'd10, 28'd1000);
        wait_idle("basic", 4000);
        check("basic_pulses", 64'(pulse_cnt - p0), 1);
        check("basic_missed", 64'(miss_cnt - m0), 0);
        check("basic_ovf", 64'(ovf_cnt - o0), 0);
        check("basic_pq", 64'(pq.size()), 0);

        // Second wrap: (7,124999000) -> (8,1500); parked at (7,1500) first
        set_time(40'd7, 28'd1500, 1'b0);
        p0 = pulse_cnt;
        pq.push_back(deadline(40'd7, 28'd124999000));
        send(40'd7, 28'd124999000);
        run(10);
        check("wrap_no_early", 64'(pulse_cnt - p0), 0);
        check("wrap_busy", 64'(busy_o), 1);
        set_time(40'd8, 28'd1400, 1'b1);
        wait_idle("wrap", 500);
        check("wrap_pulses", 64'(pulse_cnt - p0), 1);
        check("wrap_pq", 64'(pq.size()), 0);

        // Late deadline
        set_time(40'd10, 28'd4000, 1'b1);
        p0 = pulse_cnt; m0 = miss_cnt;
        mq.push_back(deadline(40'd10, 28'd1000));
        send(40'd10, 28'd1000);
        wait_idle("late", 100);
        check("late_missed", 64'(miss_cnt - m0), 1);
        check("late_pulses", 64'(pulse_cnt - p0), 0);
        check("late_mq", 64'(mq.size()), 0);

        // Overflow: five back-to-back future timestamps into a depth-4 queue
        set_time(40'd20, 28'd0, 1'b1);
        p0 = pulse_cnt; o0 = ovf_cnt; m0 = miss_cnt;
        exp_ovf = 1;
        for (int k = 1; k <= 5; k++) begin
            if (k <= DEPTH) pq.push_back(deadline(40'd20, 28'(k * 1000)));
            send(40'd20, 28'(k * 1000));
        end
        wait_idle("ovf", 8000);
        check("ovf_count", 64'(ovf_cnt - o0), 1);
        check("ovf_pulses", 64'(pulse_cnt - p0), 4);
        check("ovf_missed", 64'(miss_cnt - m0), 0);
        check("ovf_pq", 64'(pq.size()), 0);

        // Collision: second deadline 50 cycles later falls inside the first pulse
        set_time(40'd30, 28'd0, 1'b1);
        p0 = pulse_cnt; m0 = miss_cnt;
        pq.push_back(deadline(40'd30, 28'd1000));
        mq.push_back(deadline(40'd30, 28'd1050));
        send(40'd30, 28'd1000);
        send(40'd30, 28'd1050);
        wait_idle("coll", 4000);
        check("coll_pulses", 64'(pulse_cnt - p0), 1);
        check("coll_missed", 64'(miss_cnt - m0), 1);

        // Time invalid across the deadline
        set_time(40'd40, 28'd0, 1'b1);
        p0 = pulse_cnt; m0 = miss_cnt;
        send(40'd40, 28'd1000);
        run(5);
        tm_valid = 1'b0;
        set_time(40'd40, 28'd3400, 1'b1);
        run(300);
        check("inval_pulses", 64'(pulse_cnt - p0), 0);
        check("inval_missed", 64'(miss_cnt - m0), 0);
        check("inval_busy", 64'(busy_o), 1);
        mq.push_back(deadline(40'd40, 28'd1000));
        tm_valid = 1'b1;
        wait_idle("inval", 100);
        check("inval_missed_after", 64'(miss_cnt - m0), 1);
        check("inval_mq", 64'(mq.size()), 0);

        // Reset 20 cycles into a pulse with two entries still queued
        set_time(40'd50, 28'd3000, 1'b1);
        p0 = pulse_cnt; m0 = miss_cnt;
        pq.push_back(deadline(40'd50, 28'd1000));
        send(40'd50, 28'd1000);
        send(40'd50, 28'd2000);
        send(40'd50, 28'd3000);
        begin
            int n;
            n = 0;
            while (!pulse_o && n < 1000) begin
                tick();
                n++;
            end
        end
        check("rstp_rise", 64'(pulse_o), 1);
        run(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstp_pulse", 64'(pulse_o), 0);
        check("rstp_busy", 64'(busy_o), 0);
        run(2700);
        check("rstp_pulses", 64'(pulse_cnt - p0), 1);
        check("rstp_missed", 64'(miss_cnt - m0), 0);
        check("rstp_busy_end", 64'(busy_o), 0);
        check("end_pq", 64'(pq.size()), 0);
        check("end_mq", 64'(mq.size()), 0);
        check("end_ovf_pending", 64'(exp_ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trig_delayed_pulse_gen.md
# trig_delayed_pulse_gen

Receive-side half of the trigger-distribution link. It accepts trigger timestamps (TAI seconds plus 125 MHz cycles) decoded from the WR streamer RX path and adds a fixed transport delay. Each delayed deadline is queued, then regenerated as a fixed-width pulse on a DIO output when local White Rabbit time reaches it. It sits in the node top level between the streamer RX data port and the DIO output buffer.

## Interface
- g_fifo_depth, 4: number of pending deadlines held; power of two, 2..16.
- g_delay_cycles, 2500: fixed delay added to every timestamp (20 us at 8 ns); must be < g_cycles_per_sec.
- g_pulse_width, 125: output pulse width in clk_ref_i cycles (1 us); >= 1.
- g_cycles_per_sec, 125000000: cycle counter modulus.
- clk_ref_i  in  1  125 MHz WR reference clock; all logic on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- tm_time_valid_i  in  1  local WR time is valid.
- tm_tai_i  in  40  local TAI seconds.
- tm_cycles_i  in  28  local cycle count, 0..g_cycles_per_sec-1.
- ts_valid_i  in  1  one-cycle strobe: new received trigger timestamp.
- ts_tai_i  in  40  trigger TAI seconds, qualified by ts_valid_i.
- ts_cycles_i  in  28  trigger cycles, qualified by ts_valid_i.
- pulse_o  out  1  regenerated trigger pulse.
- busy_o  out  1  FIFO non-empty or pulse in progress.
- overflow_o  out  1  one-cycle strobe: timestamp dropped, FIFO full.
- missed_o  out  1  one-cycle strobe: deadline dropped because it was already past.

## Operation
- Reset (rst_n_i=0 at an edge): pulse_o=0, busy_o=0, overflow_o=0, missed_o=0. FIFO is emptied, adder stage is invalidated, FSM enters IDLE, width counter=0. Reset asserted mid-pulse takes pulse_o low on that edge.
- Adder stage, registered: sum = ts_cycles_i + g_delay_cycles, 29 bits.
  - If sum >= g_cycles_per_sec: deadline = (ts_tai_i+1, sum-g_cycles_per_sec).
  - Otherwise: deadline = (ts_tai_i, sum).
  - TAI addition is 40-bit modulo.
- FIFO write: a valid adder output is written on the next edge if the FIFO is not full.
  - If the FIFO is full, the entry is dropped and overflow_o=1 for one cycle.
  - Fullness is evaluated before a same-cycle pop, so a write arriving while full is dropped even if the head pops in that cycle.
- FSM states:
  - IDLE: FIFO empty. Goes to WAIT when the FIFO becomes non-empty.
  - WAIT: compare the head deadline with local time, only while tm_time_valid_i=1; otherwise hold.
    - Local time == deadline: pop, set pulse_o=1, load width counter with g_pulse_width-1, go to PULSE.
    - Local time > deadline (TAI greater, or TAI equal and cycles greater): pop, missed_o=1 for one cycle, stay in WAIT if FIFO still non-empty, else go to IDLE.
    - Local time < deadline: hold.
  - PULSE: decrement the counter each cycle. At 0: pulse_o=0, go to WAIT if FIFO non-empty, else IDLE. No head comparison is made in PULSE; a head that becomes past during the pulse is reported as missed on return to WAIT.
- busy_o = (FIFO non-empty) OR (state == PULSE), registered.

## Timing
- ts_valid_i to adder register: 1 edge. Adder register to FIFO entry: 1 edge. Head is comparable in WAIT from the third edge after the ts_valid_i edge.
- pulse_o rises on the edge at which sampled (tm_tai_i, tm_cycles_i) equals the deadline, so it is visible 1 cycle after local time reaches the deadline.
- pulse_o stays high exactly g_pulse_width cycles.
- The earliest next comparison is the cycle after pulse_o falls.
- overflow_o and missed_o are single-cycle strobes, never stretched. ts_valid_i on consecutive cycles is supported at full rate.

## Test plan
- Basic: ts=(10,1000) with local time running from (10,0) -> pulse_o rises on the edge sampling tm=(10,3500), high 125 cycles, missed_o and overflow_o stay 0.
- Second wrap: ts=(7,124999000) -> deadline (8,1500); pulse rises when tm=(8,1500); no pulse at (7,1500).
- Late deadline: ts=(10,1000) delivered when tm=(10,4000) -> missed_o high exactly 1 cycle, pulse_o stays 0, busy_o returns to 0.
- Overflow: 5 timestamps on consecutive cycles, all in the future, depth 4 -> one overflow_o strobe; exactly 4 pulses, in order.
- Collision and time invalid:
  - Deadlines 50 cycles apart -> first pulse is 125 cycles; second deadline yields missed_o=1 after the first pulse ends.
  - With tm_time_valid_i=0 across a deadline -> no pulse and no missed until valid returns, then missed_o.
- Reset mid-pulse: rst_n_i=0 for 1 edge, 20 cycles into a pulse with 2 queued entries -> pulse_o=0 and busy_o=0 after that edge; no further pulses.
